// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Parametrised raster timing generator. Runs on the system clock
//             with a pixel clock-enable and produces pixel positions, blanking,
//             active-low syncs, a blanked registered RGB output and line /
//             vblank strobes. Sync position and screen flip are runtime
//             controls that only take effect at a frame boundary.
//  Ports    : clk, reset      - system clock, synchronous active-high reset
//             ce_pix          - pixel clock-enable, all state advances on it
//             h_adj, v_adj    - signed sync shift (-8..+7 pixels / lines)
//             flip            - mirror HPOS / VPOS
//             iRGB / oRGB     - core colour in / registered blanked colour out
//             HPOS, VPOS      - pixel position (mod 512)
//             HBLK, VBLK      - horizontal / vertical blank
//             HS_N, VS_N      - active-low syncs
//             line_start      - one-clk strobe when hcnt wraps to 0
//             vbl_start       - one-clk strobe on VBLK rising
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 16,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 311,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 263,
    parameter int V_ACT_START  = 16,
    parameter int V_ACTIVE     = 192,
    parameter int V_SYNC_START = 235,
    parameter int V_SYNC_LEN   = 7,
    parameter int RGB_W        = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [3:0]       h_adj,
    input  logic [3:0]       v_adj,
    input  logic             flip,
    input  logic [RGB_W-1:0] iRGB,
    output logic [8:0]       HPOS,
    output logic [8:0]       VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HS_N,
    output logic             VS_N,
    output logic             line_start,
    output logic             vbl_start
);

    localparam logic [8:0] c_h_last      = 9'(H_TOTAL - 1);
    localparam logic [8:0] c_v_last      = 9'(V_TOTAL - 1);
    localparam logic [8:0] c_h_act_first = 9'(H_ACT_START);
    localparam logic [8:0] c_h_act_last  = 9'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [8:0] c_v_act_first = 9'(V_ACT_START);
    localparam logic [8:0] c_v_act_last  = 9'(V_ACT_START + V_ACTIVE - 1);
    localparam logic [9:0] c_h_sync_start = 10'(H_SYNC_START);
    localparam logic [9:0] c_h_sync_len   = 10'(H_SYNC_LEN);
    localparam logic [9:0] c_v_sync_start = 10'(V_SYNC_START);
    localparam logic [9:0] c_v_sync_len   = 10'(V_SYNC_LEN);

    logic [8:0]       r_hcnt;
    logic [8:0]       r_vcnt;
    logic [3:0]       r_sh_adj;
    logic [3:0]       r_sv_adj;
    logic             r_sflip;
    logic             r_hblk;
    logic             r_vblk;
    logic             r_hs_n;
    logic             r_vs_n;
    logic [RGB_W-1:0] r_rgb;
    logic             r_line_start;
    logic             r_vbl_start;

    logic       w_h_wrap;
    logic       w_v_last;
    logic       w_frame_wrap;
    logic [8:0] w_hcnt_nxt;
    logic [8:0] w_vcnt_nxt;
    logic [3:0] w_sh_adj_nxt;
    logic [3:0] w_sv_adj_nxt;
    logic       w_sflip_nxt;
    logic [9:0] w_hss;
    logic [9:0] w_vss;
    logic       w_hblk_nxt;
    logic       w_vblk_nxt;
    logic       w_hs_n_nxt;
    logic       w_vs_n_nxt;

    assign w_h_wrap     = (r_hcnt == c_h_last);
    assign w_v_last     = (r_vcnt == c_v_last);
    assign w_frame_wrap = w_h_wrap & w_v_last;
    assign w_hcnt_nxt   = w_h_wrap ? 9'd0 : r_hcnt + 9'd1;
    assign w_vcnt_nxt   = w_h_wrap ? (w_v_last ? 9'd0 : r_vcnt + 9'd1) : r_vcnt;

    // Controls are only captured on the frame wrap so a frame never tears.
    // Decoding below uses the value that will be live for the new count.
    assign w_sh_adj_nxt = w_frame_wrap ? h_adj : r_sh_adj;
    assign w_sv_adj_nxt = w_frame_wrap ? v_adj : r_sv_adj;
    assign w_sflip_nxt  = w_frame_wrap ? flip  : r_sflip;

    // Sign-extended sync start; parameter sets keep it inside the raster.
    assign w_hss = c_h_sync_start + {{6{w_sh_adj_nxt[3]}}, w_sh_adj_nxt};
    assign w_vss = c_v_sync_start + {{6{w_sv_adj_nxt[3]}}, w_sv_adj_nxt};

    // Blank / sync decode from the next count so the registered flags line up
    // with the counter values they describe.
    assign w_hblk_nxt = !((w_hcnt_nxt >= c_h_act_first) && (w_hcnt_nxt <= c_h_act_last));
    assign w_vblk_nxt = !((w_vcnt_nxt >= c_v_act_first) && (w_vcnt_nxt <= c_v_act_last));
    assign w_hs_n_nxt = !(({1'b0, w_hcnt_nxt} >= w_hss) &&
                          ({1'b0, w_hcnt_nxt} <  w_hss + c_h_sync_len));
    assign w_vs_n_nxt = !(({1'b0, w_vcnt_nxt} >= w_vss) &&
                          ({1'b0, w_vcnt_nxt} <  w_vss + c_v_sync_len));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt       <= 9'd0;
            r_vcnt       <= 9'd0;
            r_sh_adj     <= 4'd0;
            r_sv_adj     <= 4'd0;
            r_sflip      <= 1'b0;
            r_hblk       <= 1'b1;
            r_vblk       <= 1'b1;
            r_hs_n       <= 1'b1;
            r_vs_n       <= 1'b1;
            r_rgb        <= '0;
            r_line_start <= 1'b0;
            r_vbl_start  <= 1'b0;
        end else begin
            r_line_start <= 1'b0;
            r_vbl_start  <= 1'b0;
            if (ce_pix) begin
                r_hcnt   <= w_hcnt_nxt;
                r_vcnt   <= w_vcnt_nxt;
                r_sh_adj <= w_sh_adj_nxt;
                r_sv_adj <= w_sv_adj_nxt;
                r_sflip  <= w_sflip_nxt;
                // Uses the current blank flags: one pixel of latency that
                // matches the core's registered pixel pipeline.
                r_rgb    <= (r_hblk | r_vblk) ? '0 : iRGB;
                r_hblk   <= w_hblk_nxt;
                r_vblk   <= w_vblk_nxt;
                r_hs_n   <= w_hs_n_nxt;
                // Vertical sync only moves on a line boundary.
                if (w_h_wrap) begin
                    r_vs_n <= w_vs_n_nxt;
                end
                r_line_start <= w_h_wrap;
                r_vbl_start  <= w_vblk_nxt & ~r_vblk;
            end
        end
    end

    // Positions are a function of the registered counters and flip, so they
    // change in the same cycle as the counters (mod-512 arithmetic).
    assign HPOS = r_sflip ? (c_h_act_last - r_hcnt) : (r_hcnt - c_h_act_first);
    assign VPOS = r_sflip ? (c_v_act_last - r_vcnt) : (r_vcnt - c_v_act_first);

    assign oRGB       = r_rgb;
    assign HBLK       = r_hblk;
    assign VBLK       = r_vblk;
    assign HS_N       = r_hs_n;
    assign VS_N       = r_vs_n;
    assign line_start = r_line_start;
    assign vbl_start  = r_vbl_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Self-checking bench for video_timing_gen on a reduced raster.
//             A behavioural model produces expected outputs for every clock,
//             pushed to a scoreboard queue and compared after the edge, plus
//             per-frame directed checks (active window, sync position, flip,
//             RGB blanking, mid-frame reset and ce_pix hold).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int HT  = 40;
    localparam int HAS = 4;
    localparam int HA  = 24;
    localparam int HSS = 28;
    localparam int HSL = 4;
    localparam int VT  = 30;
    localparam int VAS = 4;
    localparam int VA  = 16;
    localparam int VSS = 20;
    localparam int VSL = 2;

    typedef struct {
        logic [8:0]  hpos;
        logic [8:0]  vpos;
        logic [11:0] rgb;
        logic        hblk;
        logic        vblk;
        logic        hs_n;
        logic        vs_n;
        logic        ls;
        logic        vbs;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ce_pix;
    logic [3:0]  h_adj;
    logic [3:0]  v_adj;
    logic        flip;
    logic [11:0] iRGB;
    logic [8:0]  HPOS;
    logic [8:0]  VPOS;
    logic [11:0] oRGB;
    logic        HBLK;
    logic        VBLK;
    logic        HS_N;
    logic        VS_N;
    logic        line_start;
    logic        vbl_start;

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .RGB_W(12)
    ) u_dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .h_adj(h_adj), .v_adj(v_adj), .flip(flip), .iRGB(iRGB),
        .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
        .HBLK(HBLK), .VBLK(VBLK), .HS_N(HS_N), .VS_N(VS_N),
        .line_start(line_start), .vbl_start(vbl_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int   m_h, m_v, m_sh, m_sv;
    logic m_sf, m_hblk, m_vblk, m_hs, m_vs, m_ls, m_vbs;
    logic [11:0] m_rgb;

    exp_t sb_q[$];

    // Directed statistics
    logic rgb_fff;
    logic fr_flip;
    logic prev_hs, prev_vs;
    int   act_cnt, nz_cnt, ls_cnt, vbs_cnt, st_cnt;
    int   first_h, first_v, last_h, last_v;
    int   hs_falls, hs_min, hs_max, vs_falls, vs_pos;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sx4(input logic [3:0] a);
        return a[3] ? int'(a) - 16 : int'(a);
    endfunction

    task automatic model_step(input logic ce, input logic rst, input logic [3:0] ha,
                              input logic [3:0] va, input logic fl, input logic [11:0] rgb);
        int   nh, nv, hs0, vs0;
        logic hw, nhb, nvb;
        if (rst) begin
            m_h = 0; m_v = 0; m_sh = 0; m_sv = 0; m_sf = 1'b0;
            m_hblk = 1'b1; m_vblk = 1'b1; m_hs = 1'b1; m_vs = 1'b1;
            m_rgb = 12'h000; m_ls = 1'b0; m_vbs = 1'b0;
        end else if (!ce) begin
            m_ls = 1'b0; m_vbs = 1'b0;
        end else begin
            hw = (m_h == HT - 1);
            nh = hw ? 0 : m_h + 1;
            nv = m_v;
            if (hw) nv = (m_v == VT - 1) ? 0 : m_v + 1;
            if (hw && m_v == VT - 1) begin
                m_sh = sx4(ha); m_sv = sx4(va); m_sf = fl;
            end
            m_rgb = (m_hblk || m_vblk) ? 12'h000 : rgb;
            nhb = !(nh >= HAS && nh < HAS + HA);
            nvb = !(nv >= VAS && nv < VAS + VA);
            m_ls  = hw;
            m_vbs = nvb && !m_vblk;
            hs0 = HSS + m_sh;
            m_hs = !(nh >= hs0 && nh < hs0 + HSL);
            if (hw) begin
                vs0 = VSS + m_sv;
                m_vs = !(nv >= vs0 && nv < vs0 + VSL);
            end
            m_h = nh; m_v = nv; m_hblk = nhb; m_vblk = nvb;
        end
    endtask

    // One clock: drive at the falling edge, predict, compare 1 ns after rise.
    task automatic tick(input logic ce, input logic rst);
        exp_t e;
        int   hc, vc;
        ce_pix = ce;
        reset  = rst;
        iRGB   = rgb_fff ? 12'hFFF : 12'($urandom);
        model_step(ce, rst, h_adj, v_adj, flip, iRGB);
        e.hpos = 9'(m_sf ? (HAS + HA - 1 - m_h) : (m_h - HAS));
        e.vpos = 9'(m_sf ? (VAS + VA - 1 - m_v) : (m_v - VAS));
        e.rgb  = m_rgb; e.hblk = m_hblk; e.vblk = m_vblk;
        e.hs_n = m_hs;  e.vs_n = m_vs;   e.ls = m_ls; e.vbs = m_vbs;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("hpos",       32'(HPOS),       32'(e.hpos));
        chk("vpos",       32'(VPOS),       32'(e.vpos));
        chk("orgb",       32'(oRGB),       32'(e.rgb));
        chk("hblk",       32'(HBLK),       32'(e.hblk));
        chk("vblk",       32'(VBLK),       32'(e.vblk));
        chk("hs_n",       32'(HS_N),       32'(e.hs_n));
        chk("vs_n",       32'(VS_N),       32'(e.vs_n));
        chk("line_start", 32'(line_start), 32'(e.ls));
        chk("vbl_start",  32'(vbl_start),  32'(e.vbs));
        // Directed statistics taken from DUT outputs only
        if (ce && !rst) begin
            if (!HBLK && !VBLK) begin
                if (act_cnt == 0) begin first_h = int'(HPOS); first_v = int'(VPOS); end
                last_h = int'(HPOS); last_v = int'(VPOS);
                act_cnt++;
            end
            if (oRGB != 12'h000) nz_cnt++;
        end
        hc = fr_flip ? ((HAS + HA - 1 - int'(HPOS)) & 511) : ((int'(HPOS) + HAS) & 511);
        vc = fr_flip ? ((VAS + VA - 1 - int'(VPOS)) & 511) : ((int'(VPOS) + VAS) & 511);
        if (prev_hs && !HS_N) begin
            hs_falls++;
            if (hc < hs_min) hs_min = hc;
            if (hc > hs_max) hs_max = hc;
        end
        if (prev_vs && !VS_N) begin
            vs_falls++;
            vs_pos = vc;
        end
        prev_hs = HS_N;
        prev_vs = VS_N;
        ls_cnt  += int'(line_start);
        vbs_cnt += int'(vbl_start);
        st_cnt  += int'(line_start) + int'(vbl_start);
        @(negedge clk);
    endtask

    // One full frame with ce_pix every second clock, starting at hcnt=vcnt=0.
    // New controls are written halfway through and must not affect this frame.
    task automatic run_frame(input string nm, input logic fl_now, input int hs_exp,
                             input int vs_exp, input logic [3:0] nha,
                             input logic [3:0] nva, input logic nfl);
        act_cnt = 0; nz_cnt = 0; ls_cnt = 0; vbs_cnt = 0;
        hs_falls = 0; hs_min = 9999; hs_max = -1; vs_falls = 0; vs_pos = -1;
        first_h = -1; first_v = -1; last_h = -1; last_v = -1;
        fr_flip = fl_now;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (i == HT * VT) begin
                h_adj = nha; v_adj = nva; flip = nfl;
            end
            tick((i % 2) == 1, 1'b0);
        end
        chk({nm, "_active_px"}, 32'(act_cnt), 32'(HA * VA));
        chk({nm, "_line_strobes"}, 32'(ls_cnt), 32'(VT));
        chk({nm, "_vbl_strobes"}, 32'(vbs_cnt), 32'd1);
        chk({nm, "_hs_falls"}, 32'(hs_falls), 32'(VT));
        chk({nm, "_hs_start_min"}, 32'(hs_min), 32'(hs_exp));
        chk({nm, "_hs_start_max"}, 32'(hs_max), 32'(hs_exp));
        chk({nm, "_vs_falls"}, 32'(vs_falls), 32'd1);
        chk({nm, "_vs_start"}, 32'(vs_pos), 32'(vs_exp));
        chk({nm, "_first_hpos"}, 32'(first_h), fl_now ? 32'(HA - 1) : 32'd0);
        chk({nm, "_first_vpos"}, 32'(first_v), fl_now ? 32'(VA - 1) : 32'd0);
        chk({nm, "_last_hpos"},  32'(last_h),  fl_now ? 32'd0 : 32'(HA - 1));
        chk({nm, "_last_vpos"},  32'(last_v),  fl_now ? 32'd0 : 32'(VA - 1));
        if (rgb_fff) chk({nm, "_rgb_nonzero"}, 32'(nz_cnt), 32'(HA * VA));
    endtask

    initial begin
        logic found;
        reset = 1'b1; ce_pix = 1'b0; h_adj = 4'd0; v_adj = 4'd0; flip = 1'b0;
        iRGB = 12'h000; rgb_fff = 1'b0; fr_flip = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1; st_cnt = 0;
        act_cnt = 0; nz_cnt = 0; ls_cnt = 0; vbs_cnt = 0;
        hs_falls = 0; hs_min = 0; hs_max = 0; vs_falls = 0; vs_pos = 0;
        first_h = 0; first_v = 0; last_h = 0; last_v = 0;

        // Reset state (ce_pix high to show it is ignored under reset)
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        chk("reset_hpos", 32'(HPOS), 32'd508);
        chk("reset_hblk", 32'(HBLK), 32'd1);

        // Frame A: defaults; adj +3 / -2 and flip written mid-frame
        run_frame("frameA", 1'b0, HSS, VSS, 4'd3, 4'hE, 1'b1);
        // Frame B: shifted syncs and flipped positions; controls restored mid-frame
        rgb_fff = 1'b0;
        run_frame("frameB", 1'b1, HSS + 3, VSS - 2, 4'd0, 4'd0, 1'b0);
        // Frame C: unflipped, iRGB held at FFF
        rgb_fff = 1'b1;
        run_frame("frameC", 1'b0, HSS, VSS, 4'd0, 4'd0, 1'b0);
        rgb_fff = 1'b0;

        // Continuous ce_pix, then random ce_pix with random controls
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 0) begin
                h_adj = 4'($urandom); v_adj = 4'($urandom); flip = 1'($urandom);
            end
            tick(1'($urandom_range(0, 1)), 1'b0);
        end

        // Reach hcnt=20, vcnt=10 then reset with ce_pix low
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !found; i++) begin
            if (m_h == 20 && m_v == 10) found = 1'b1;
            else tick(1'b1, 1'b0);
        end
        chk("reach_reset_point", 32'(found), 32'd1);
        tick(1'b0, 1'b1);
        chk("midrst_hpos", 32'(HPOS), 32'd508);
        chk("midrst_vpos", 32'(VPOS), 32'd508);
        chk("midrst_hblk", 32'(HBLK), 32'd1);
        chk("midrst_vblk", 32'(VBLK), 32'd1);
        chk("midrst_hs_n", 32'(HS_N), 32'd1);
        chk("midrst_vs_n", 32'(VS_N), 32'd1);
        chk("midrst_orgb", 32'(oRGB), 32'd0);

        // ce_pix low for 10 clocks: frozen, no strobes
        st_cnt = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        chk("hold_strobes", 32'(st_cnt), 32'd0);
        chk("hold_hpos", 32'(HPOS), 32'd508);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
